gpr_dump: RTL and testbench
===========================

// Module: gpr_dump
// PURPOSE
//  Debug reader for the general purpose register file: on command, walks a register
//  range through the register file's test read port and streams each 32-bit value
//  out as bytes (MSB first) over a valid/ready byte interface (e.g. to a UART TX or LED pager).
//  Sits beside the CPU datapath; never writes the register file.
// PARAMETERS
//  FIRST_REG  0   first register index dumped (0..31)
//  LAST_REG   31  last register index dumped (FIRST_REG..31; LAST_REG < FIRST_REG is illegal)
// PORTS
//  clock         in   1   single clock, all state on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  i_start       in   1   start a dump; sampled only in IDLE
//  o_busy        out  1   high from the cycle after accepted start until DONE exits
//  o_done        out  1   one-cycle pulse when the last byte has been accepted
//  o_rf_addr     out  5   address to register file test read port
//  i_rf_data     in   32  combinational read data for o_rf_addr
//  o_byte_valid  out  1   o_byte holds a valid byte
//  o_byte        out  8   output byte
//  i_byte_ready  in   1   sink accepts o_byte this cycle when o_byte_valid is high
// BEHAVIOUR
//  - Reset: state=IDLE; o_busy=0, o_done=0, o_rf_addr=FIRST_REG, o_byte_valid=0, o_byte=0,
//    shift reg, byte count, checksum all 0. Reset mid-dump aborts instantly; no o_done.
//  - States: IDLE, LOAD, SEND, (CSUM), DONE.
//  - IDLE: i_start=1 -> o_rf_addr<=FIRST_REG, checksum<=0, -> LOAD. o_busy=0.
//  - LOAD (1 cycle): shift<=i_rf_data, byte_cnt<=0 -> SEND. o_byte_valid=0.
//  - SEND: o_byte_valid=1, o_byte=shift[31:24]. Handshake = valid & ready.
//    On handshake: shift<=shift<<8, byte_cnt++, checksum^=o_byte.
//    Handshake on byte_cnt==3: if o_rf_addr==LAST_REG -> CSUM (if enabled) else DONE;
//    otherwise o_rf_addr++ -> LOAD.
//  - No handshake: o_byte, o_byte_valid, o_rf_addr held stable (no drop, no repeat).
//  - DONE (1 cycle): o_done=1, o_busy=0 next cycle, -> IDLE. o_rf_addr<=FIRST_REG.
//  - i_start while not IDLE is ignored (no restart, no queueing); i_start held high
//    in IDLE after DONE starts a new dump.
//  - Snapshot semantics: each register captured at its LOAD cycle; CPU writes to not
//    yet loaded registers appear in the dump, writes to loaded ones do not.
//  - Latency (ready=1): start at cycle N -> LOAD at N+1, first byte valid N+2;
//    5 cycles per register; o_done at N+1+5*(LAST_REG-FIRST_REG+1) (+1 with CSUM).
//  - o_rf_addr never leaves [FIRST_REG, LAST_REG]; no wrap past 31.
// CONFIGURATION
//  GPR_DUMP_CSUM_EN defined: after the last register byte, CSUM state drives
//    o_byte_valid=1, o_byte=XOR of all bytes sent; on handshake -> DONE. Same hold rules.
//  Not defined: CSUM state and checksum register absent; last data byte -> DONE.
// TESTING
//  1 FIRST=0,LAST=1, r1=0x12345678, ready=1 -> bytes 00 00 00 00 12 34 56 78,
//    o_done pulse one cycle after byte 78 accepted, o_busy low after.
//  2 Same, ready low 3 cycles while o_byte=0x34 -> 0x34 held valid 3 cycles, no skip,
//    stream identical to test 1.
//  3 CSUM_EN, test 1 setup -> extra byte 0x08 after 0x78, then o_done.
//  4 i_start pulsed during SEND of byte 2 -> ignored; exactly 8 bytes, one o_done.
//  5 reset_n low during SEND of r1 -> next cycle all outputs at reset values,
//    no o_done; new start gives full correct stream.
//  6 FIRST=0,LAST=31, r[i]=i*0x01010101, ready=1 -> 128 bytes in order,
//    o_done at start+161 (no CSUM), o_rf_addr stays 0..31.

Source files
------------

// File: rtl/gpr_dump.sv
// gpr_dump: walks registers FIRST_REG..LAST_REG through the register file test read port
// and streams each 32-bit value MSB-first over a valid/ready byte interface.
// Optional trailing XOR checksum byte when GPR_DUMP_CSUM_EN is defined.
module gpr_dump #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic [4:0]  o_rf_addr,
   input  logic [31:0] i_rf_data,
   output logic        o_byte_valid,
   output logic [7:0]  o_byte,
   input  logic        i_byte_ready
);

   localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
   localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

`ifdef GPR_DUMP_CSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
   logic [7:0] checksum;
`else
   typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

   state_t      state;
   logic [31:0] shift;
   logic [1:0]  byte_cnt;
   logic        hs;

   // The outgoing byte is always the top of the shift register, so it is a flop output.
   assign o_byte = shift[31:24];
   assign hs     = o_byte_valid & i_byte_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_rf_addr    <= FIRST_ADDR;
         o_byte_valid <= 1'b0;
         shift        <= '0;
         byte_cnt     <= '0;
`ifdef GPR_DUMP_CSUM_EN
         checksum     <= '0;
`endif
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_rf_addr <= FIRST_ADDR;
                  o_busy    <= 1'b1;
`ifdef GPR_DUMP_CSUM_EN
                  checksum  <= '0;
`endif
                  state     <= LOAD;
               end
            end

            LOAD: begin
               shift        <= i_rf_data;
               byte_cnt     <= '0;
               o_byte_valid <= 1'b1;
               state        <= SEND;
            end

            SEND: begin
               if (hs) begin
                  shift    <= {shift[23:0], 8'h00};
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef GPR_DUMP_CSUM_EN
                  checksum <= checksum ^ o_byte;
`endif
                  if (byte_cnt == 2'd3) begin
                     if (o_rf_addr == LAST_ADDR) begin
`ifdef GPR_DUMP_CSUM_EN
                        // Checksum byte must include the byte accepted this cycle.
                        shift        <= {checksum ^ o_byte, 24'h000000};
                        state        <= CSUM;
`else
                        o_byte_valid <= 1'b0;
                        o_done       <= 1'b1;
                        state        <= DONE;
`endif
                     end else begin
                        o_rf_addr    <= o_rf_addr + 5'd1;
                        o_byte_valid <= 1'b0;
                        state        <= LOAD;
                     end
                  end
               end
            end

`ifdef GPR_DUMP_CSUM_EN
            CSUM: begin
               if (hs) begin
                  shift        <= '0;
                  o_byte_valid <= 1'b0;
                  o_done       <= 1'b1;
                  state        <= DONE;
               end
            end
`endif

            DONE: begin
               o_busy    <= 1'b0;
               o_rf_addr <= FIRST_ADDR;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpr_dump.sv
// Bench for gpr_dump: three instances (0..1, 0..31, 29..31) sharing one register file array,
// byte streams compared against a snapshot model of the register file.
`timescale 1ns/1ps
module tb_gpr_dump;

`ifdef GPR_DUMP_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        ready = 1'b0;
   int          sel = 0;
   logic [31:0] rf [32];

   logic        busy_a, done_a, bv_a, busy_b, done_b, bv_b, busy_c, done_c, bv_c;
   logic [4:0]  addr_a, addr_b, addr_c;
   logic [7:0]  byte_a, byte_b, byte_c;
   logic [31:0] data_a, data_b, data_c;
   logic        start_a, start_b, start_c;
   logic        busy, done, bv;
   logic [4:0]  addr;
   logic [7:0]  obyte;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   assign data_a  = rf[addr_a];
   assign data_b  = rf[addr_b];
   assign data_c  = rf[addr_c];
   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);
   assign busy  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
   assign done  = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
   assign bv    = (sel == 0) ? bv_a   : (sel == 1) ? bv_b   : bv_c;
   assign addr  = (sel == 0) ? addr_a : (sel == 1) ? addr_b : addr_c;
   assign obyte = (sel == 0) ? byte_a : (sel == 1) ? byte_b : byte_c;

   gpr_dump #(.FIRST_REG(0), .LAST_REG(1)) dut_a (
      .clock(clock), .reset_n(reset_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
      .o_rf_addr(addr_a), .i_rf_data(data_a), .o_byte_valid(bv_a), .o_byte(byte_a),
      .i_byte_ready(ready));
   gpr_dump #(.FIRST_REG(0), .LAST_REG(31)) dut_b (
      .clock(clock), .reset_n(reset_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
      .o_rf_addr(addr_b), .i_rf_data(data_b), .o_byte_valid(bv_b), .o_byte(byte_b),
      .i_byte_ready(ready));
   gpr_dump #(.FIRST_REG(29), .LAST_REG(31)) dut_c (
      .clock(clock), .reset_n(reset_n), .i_start(start_c), .o_busy(busy_c), .o_done(done_c),
      .o_rf_addr(addr_c), .i_rf_data(data_c), .o_byte_valid(bv_c), .o_byte(byte_c),
      .i_byte_ready(ready));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int first);
      chk({tag, "_busy"},  32'(busy),  32'd0);
      chk({tag, "_done"},  32'(done),  32'd0);
      chk({tag, "_valid"}, 32'(bv),    32'd0);
      chk({tag, "_addr"},  32'(addr),  32'(first));
   endtask

   // rmode: 0 ready always high, 1 random ready, 2 ready low for 3 cycles while byte 0x34 is shown.
   // pulse_k: cycle at which a stray start is pulsed; mod_k: cycle at which registers are rewritten.
   task automatic run_dump(input int s, input int first, input int last, input int rmode,
                           input int pulse_k, input int mod_k);
      logic [7:0]  got[$];
      logic [7:0]  expq[$];
      logic [31:0] snap [32];
      logic [7:0]  held, cs;
      logic [4:0]  held_addr;
      bit          stalled, fin;
      int          done_k, stall_cyc, stalls34, cur, n;
      sel = s;
      snap = rf;
      done_k = -1; stall_cyc = 0; stalls34 = 0; stalled = 0; fin = 0;
      held = '0; held_addr = '0;
      @(posedge clock); #1 start = 1'b1; ready = 1'b1;
      @(posedge clock);
      for (int k = 0; k < 3000 && !fin; k++) begin
         #1;
         start = (k == pulse_k);
         case (rmode)
            0: ready = 1'b1;
            1: ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (bv && obyte == 8'h34 && stalls34 < 3) begin
                  ready = 1'b0;
                  stalls34++;
               end else ready = 1'b1;
            end
         endcase
         if (k == mod_k && bv) begin
            // register currently on the wire is already captured; later ones are not
            cur = first + got.size() / 4;
            if (cur <= last) rf[cur] = ~rf[cur];
            if (cur < last) begin
               rf[last] = $urandom;
               snap[last] = rf[last];
            end
         end
         @(negedge clock);
         chk("busy_during", 32'(busy), 32'd1);
         chk("addr_range", 32'(int'(addr) >= first && int'(addr) <= last), 32'd1);
         if (stalled) begin
            chk("hold_valid", 32'(bv), 32'd1);
            chk("hold_byte", 32'(obyte), 32'(held));
            chk("hold_addr", 32'(addr), 32'(held_addr));
         end
         stalled   = bv && !ready;
         held      = obyte;
         held_addr = addr;
         if (stalled) stall_cyc++;
         if (bv && ready) got.push_back(obyte);
         if (done) begin
            done_k = k;
            fin = 1'b1;
         end
         @(posedge clock);
      end
      chk("done_seen", 32'(fin), 32'd1);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk_idle("after_done", first);
         @(posedge clock);
      end
      cs = '0;
      for (int r = first; r <= last; r++)
         for (int b = 3; b >= 0; b--) begin
            expq.push_back(snap[r][8*b +: 8]);
            cs ^= snap[r][8*b +: 8];
         end
      if (CSUM) expq.push_back(cs);
      chk("byte_count", 32'(got.size()), 32'(expq.size()));
      n = (got.size() < expq.size()) ? got.size() : expq.size();
      for (int i = 0; i < n; i++) chk($sformatf("byte%0d", i), 32'(got[i]), 32'(expq[i]));
      chk("done_cycle", 32'(done_k), 32'((last - first + 1) + expq.size() + stall_cyc));
      if (rmode == 2) chk("stall_cycles", 32'(stall_cyc), 32'd3);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      repeat (2) @(posedge clock);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk_idle("reset", (s == 2) ? 29 : 0);
         chk("reset_byte", 32'(obyte), 32'd0);
      end
      @(posedge clock); #1 reset_n = 1'b1;

      // basic two-register dump, then stalled, then stray start
      rf[0] = 32'h0;
      rf[1] = 32'h12345678;
      run_dump(0, 0, 1, 0, -1, -1);
      run_dump(0, 0, 1, 2, -1, -1);
      run_dump(0, 0, 1, 0, 3, -1);

      // abort mid-dump with reset
      sel = 0;
      @(posedge clock); #1 start = 1'b1; ready = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (7) @(posedge clock);
      #1 reset_n = 1'b0;
      @(negedge clock);
      chk_idle("abort", 0);
      chk("abort_byte", 32'(obyte), 32'd0);
      @(posedge clock); #1 reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         chk_idle("post_abort", 0);
      end
      run_dump(0, 0, 1, 0, -1, -1);

      // full register file, patterned
      for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
      run_dump(1, 0, 31, 0, -1, -1);

      // random contents, random back-pressure, mid-dump writes
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      run_dump(1, 0, 31, 1, -1, 40);
      run_dump(0, 0, 1, 1, -1, 2);
      run_dump(2, 29, 31, 1, 5, 7);
      run_dump(2, 29, 31, 0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
